// File: rtl/lcd_wr_arbiter_if.sv
// Handshake bundle joining the init sequencer, the two drawing clients and the SPI word writer.
interface lcd_wr_arbiter_if;
  logic        init_done;
  logic        init_en;
  logic [8:0]  init_data;
  logic        init_wr_done;
  logic [1:0]  cli_req;
  logic [17:0] cli_data;
  logic [1:0]  cli_last;
  logic [1:0]  cli_grant;
  logic [1:0]  cli_ack;
  logic        wr_en;
  logic [8:0]  wr_data;
  logic        wr_done;
  logic        timeout_err;

  // Arbiter side: owns the writer, serves sequencer and clients.
  modport master (
    input  init_done, init_en, init_data, cli_req, cli_data, cli_last, wr_done,
    output init_wr_done, cli_grant, cli_ack, wr_en, wr_data, timeout_err
  );

  // Environment side: sequencer, clients and writer.
  modport slave (
    output init_done, init_en, init_data, cli_req, cli_data, cli_last, wr_done,
    input  init_wr_done, cli_grant, cli_ack, wr_en, wr_data, timeout_err
  );
endinterface

// File: rtl/lcd_wr_arbiter.sv
// LCD SPI writer arbiter: passes the power-up stream through until init_done, then shares
// the writer between two burst-locked clients in round-robin order, with a wr_done watchdog.
module lcd_wr_arbiter #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
  parameter logic [8:0]  DATA_IDLE   = 9'h000
) (
  input  logic             sys_clk_50MHz,
  input  logic             sys_rst,
  lcd_wr_arbiter_if.master bus
);

  localparam int unsigned WORD_W = 9;
  localparam int unsigned WDOG_W = 24;

  // S_ACK holds one cycle after an acked word so the client can present its next word
  // before S_LOAD samples it.
  typedef enum logic [2:0] {
    S_INIT,
    S_ARB,
    S_LOAD,
    S_XFER,
    S_ACK,
    S_GAP
  } state_t;

  state_t              state_q;
  logic                wr_en_q;
  logic [WORD_W-1:0]   wr_data_q;
  logic [1:0]          grant_q;
  logic [1:0]          ack_q;
  logic                timeout_err_q;
  logic                rr_ptr_q;
  logic                g_q;
  logic                last_q;
  logic [WDOG_W-1:0]   wdog_q;

  logic [WORD_W-1:0]   cli_word_c;
  logic                cli_last_c;
  logic                cli_req_c;
  logic                arb_pick_c;
  logic                wdog_expired_c;

  // Current word/flags of the granted client and the arbitration choice.
  assign cli_word_c     = g_q ? bus.cli_data[17:9] : bus.cli_data[8:0];
  assign cli_last_c     = bus.cli_last[g_q];
  assign cli_req_c      = bus.cli_req[g_q];
  assign arb_pick_c     = (bus.cli_req == 2'b11) ? rr_ptr_q : bus.cli_req[1];
  assign wdog_expired_c = (wdog_q == (TIMEOUT_CYC - WDOG_W'(1)));

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.cli_grant    = grant_q;
  assign bus.cli_ack      = ack_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.init_wr_done = bus.wr_done & (state_q == S_INIT);

  // Arbiter FSM with registered outputs and saturating watchdog.
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= S_INIT;
      wr_en_q       <= 1'b0;
      wr_data_q     <= DATA_IDLE;
      grant_q       <= 2'b00;
      ack_q         <= 2'b00;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= 1'b0;
      g_q           <= 1'b0;
      last_q        <= 1'b0;
      wdog_q        <= '0;
    end else begin
      ack_q  <= 2'b00;
      wdog_q <= '0;
      case (state_q)
        S_INIT: begin
          if (bus.init_done) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= DATA_IDLE;
            state_q   <= S_ARB;
          end else begin
            wr_en_q   <= bus.init_en;
            wr_data_q <= bus.init_en ? bus.init_data : DATA_IDLE;
          end
        end
        S_ARB: begin
          wr_en_q   <= 1'b0;
          wr_data_q <= DATA_IDLE;
          if (|bus.cli_req) begin
            g_q     <= arb_pick_c;
            grant_q <= arb_pick_c ? 2'b10 : 2'b01;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A client that dropped its request after the previous ack ends the burst here.
          if (!cli_req_c) begin
            state_q <= S_GAP;
          end else begin
            wr_data_q <= cli_word_c;
            last_q    <= cli_last_c;
            wr_en_q   <= 1'b1;
            state_q   <= S_XFER;
          end
        end
        S_XFER: begin
          if (bus.wr_done) begin
            ack_q     <= grant_q;
            wr_en_q   <= 1'b0;
            wr_data_q <= DATA_IDLE;
            state_q   <= (last_q || !cli_req_c) ? S_GAP : S_ACK;
          end else if (wdog_expired_c) begin
            timeout_err_q <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_data_q     <= DATA_IDLE;
            state_q       <= S_GAP;
          end else begin
            wdog_q <= (&wdog_q) ? wdog_q : wdog_q + WDOG_W'(1);
          end
        end
        S_ACK: begin
          state_q <= S_LOAD;
        end
        S_GAP: begin
          wr_en_q   <= 1'b0;
          wr_data_q <= DATA_IDLE;
          grant_q   <= 2'b00;
          rr_ptr_q  <= ~g_q;
          state_q   <= S_ARB;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule
